// File: rtl/nios2_jtag_debug_scan_driver.sv
// Purpose : drives the Nios II debug virtual-JTAG port (tck/tdi/ir_in/strobes) and returns captured tdo.
// Latency : rsp_valid_o (DR_WIDTH+4)*2*TCK_HALF clk after accept; (DR_WIDTH+3)*2*TCK_HALF when UIR is skipped.
// Backpres: cmd_ready_o low for the whole scan; cmd_valid_i ignored while busy. Option: NIOS2_JTAG_SCAN_IR_CACHE_EN.
module nios2_jtag_debug_scan_driver #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_HALF = 2
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IR_WIDTH-1:0] cmd_ir_i,
  input  logic [DR_WIDTH-1:0] cmd_dr_i,
  output logic                rsp_valid_o,
  output logic [DR_WIDTH-1:0] rsp_dr_o,
  output logic                vji_tck_o,
  output logic                vji_tdi_o,
  input  logic                vji_tdo_i,
  output logic [IR_WIDTH-1:0] vji_ir_in_o,
  output logic                vji_uir_o,
  output logic                vji_cdr_o,
  output logic                vji_sdr_o,
  output logic                vji_udr_o,
  output logic                vji_rti_o
);

  localparam int unsigned DIV_W = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
  localparam int unsigned CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UIR   = 3'd1,
    S_CDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_UDR   = 3'd4,
    S_RTI   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DR_WIDTH-1:0] shreg_q, shreg_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;

  logic tck_toggle;
  logic tck_rise;
  logic tck_fall;
  logic scan_done;
  logic skip_uir;

  // The divider only runs while busy, so tck idles low and its first rise
  // lands exactly TCK_HALF cycles after the accepting edge.
  assign tck_toggle = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign tck_rise   = tck_toggle && !tck_q;
  assign tck_fall   = tck_toggle &&  tck_q;
  assign scan_done  = (state_q == S_RTI) && tck_fall;

`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
  logic                cache_vld_q, cache_vld_d;
  logic [IR_WIDTH-1:0] cache_ir_q, cache_ir_d;

  // A repeat of the last completed scan's IR needs no Update-IR period.
  assign skip_uir = cache_vld_q && (cmd_ir_i == cache_ir_q);

  // Remember the IR of each completed scan; aborted scans never update it.
  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_ir_d  = cache_ir_q;
    if (scan_done) begin
      cache_vld_d = 1'b1;
      cache_ir_d  = ir_q;
    end
  end

  // Cache state register; reset invalidates it so the first scan runs UIR.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cache_vld_q <= 1'b0;
      cache_ir_q  <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_ir_q  <= cache_ir_d;
    end
  end
`else
  assign skip_uir = 1'b0;
`endif

  // Next-state logic: tck generation, shifting on tck rise, FSM/tdi on tck fall.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    tck_d     = tck_q;
    tdi_d     = tdi_q;
    ir_d      = ir_q;
    rsp_vld_d = 1'b0;
    rsp_dr_d  = rsp_dr_q;

    if (state_q == S_IDLE) begin
      div_d = '0;
      tck_d = 1'b0;
      tdi_d = 1'b0;
      if (cmd_valid_i) begin
        ir_d    = cmd_ir_i;
        shreg_d = cmd_dr_i;
        cnt_d   = '0;
        state_d = skip_uir ? S_CDR : S_UIR;
      end
    end else begin
      div_d = tck_toggle ? '0 : (div_q + DIV_W'(1));
      if (tck_toggle) begin
        tck_d = !tck_q;
      end

      // Capture tdo at the top of the shift register so bit0 ends up holding
      // the first captured bit after DR_WIDTH shifts.
      if (tck_rise && (state_q == S_SHIFT)) begin
        shreg_d = {vji_tdo_i, shreg_q[DR_WIDTH-1:1]};
      end

      if (tck_fall) begin
        unique case (state_q)
          S_UIR: begin
            state_d = S_CDR;
          end
          S_CDR: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            tdi_d   = shreg_q[0];
          end
          S_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_UDR;
              tdi_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
              tdi_d = shreg_q[0];
            end
          end
          S_UDR: begin
            state_d = S_RTI;
          end
          S_RTI: begin
            state_d = S_IDLE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end

      if (scan_done) begin
        rsp_vld_d = 1'b1;
        rsp_dr_d  = shreg_q;
      end
    end
  end

  // State register; reset aborts any scan in flight without a response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      tck_q     <= 1'b0;
      tdi_q     <= 1'b0;
      ir_q      <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dr_q  <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      tck_q     <= tck_d;
      tdi_q     <= tdi_d;
      ir_q      <= ir_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dr_q  <= rsp_dr_d;
    end
  end

  // Strobes decode the registered state, so they only move on tck falling edges.
  assign cmd_ready_o = (state_q == S_IDLE);
  assign vji_uir_o   = (state_q == S_UIR);
  assign vji_cdr_o   = (state_q == S_CDR);
  assign vji_sdr_o   = (state_q == S_SHIFT);
  assign vji_udr_o   = (state_q == S_UDR);
  assign vji_rti_o   = (state_q == S_RTI);
  assign vji_tck_o   = tck_q;
  assign vji_tdi_o   = tdi_q;
  assign vji_ir_in_o = ir_q;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_dr_o    = rsp_dr_q;

endmodule
